// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// cache_controller : MSI per-cache control FSM driving cache_datapath, peer
// snoops and the shared memory bus. Option macro: CACHE_CTRL_PERF_EN.
// Revision: 1.0
// ============================================================================
module cache_controller #(
    parameter int SNOOP_WAIT = 4,
    parameter int MAX_REPLAY = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p_req,
    input  logic             p_we,
    input  logic             read_hit,
    input  logic [1:0]       stat,
    input  logic             snoop_ready,
    input  logic             snoop_hit,
    input  logic             bus_grant,
    input  logic             mem_ack,
    output logic [1:0]       func,
    output logic             snoop_out,
    output logic             snoop_fill,
    output logic             bus_req,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             p_ready,
    output logic             p_err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [1:0] C_F_PREAD  = 2'b00;
    localparam logic [1:0] C_F_PWRITE = 2'b01;
    localparam logic [1:0] C_F_BREAD  = 2'b10;
    localparam logic [1:0] C_F_BWRITE = 2'b11;

    localparam int C_RW = $clog2(MAX_REPLAY + 2);
    localparam int C_SW = $clog2(SNOOP_WAIT + 1);
    localparam logic [C_RW-1:0] C_MAX_REPLAY = C_RW'(MAX_REPLAY);
    localparam logic [C_SW-1:0] C_SNOOP_LAST = C_SW'(SNOOP_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_SNOOP  = 3'd3,
        S_BUS_RD = 3'd4,
        S_FILL   = 3'd5,
        S_WRITE  = 3'd6,
        S_RESP   = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_we;
    logic            r_err;
    logic            r_granted;
    logic [C_RW-1:0] r_replay;
    logic [C_SW-1:0] r_snoop_cnt;
    logic            w_strobe;
    logic            w_lookup_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        func         = C_F_PREAD;
        snoop_out    = 1'b0;
        snoop_fill   = 1'b0;
        bus_req      = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        p_ready      = 1'b0;
        p_err        = 1'b0;
        // Once granted, the strobe stays up even if the arbiter withdraws grant
        w_strobe     = r_granted | bus_grant;
        w_lookup_err = (r_replay > C_MAX_REPLAY);

        case (r_state)
            S_IDLE: begin
                if (p_req) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_lookup_err) begin
                    w_next = S_RESP;
                end else if (read_hit) begin
                    w_next = r_we ? S_WRITE : S_RESP;
                end else if (stat == 2'b11) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_SNOOP;
                end
            end
            S_WB: begin
                bus_req = 1'b1;
                if (w_strobe) begin
                    func   = C_F_BWRITE;
                    mem_wr = 1'b1;
                    if (mem_ack) begin
                        w_next = S_SNOOP;
                    end
                end
            end
            S_SNOOP: begin
                snoop_out = 1'b1;
                if (snoop_ready) begin
                    w_next = snoop_hit ? S_FILL : S_BUS_RD;
                end else if (r_snoop_cnt == C_SNOOP_LAST) begin
                    w_next = S_BUS_RD;
                end
            end
            S_BUS_RD: begin
                bus_req = 1'b1;
                if (w_strobe) begin
                    func   = C_F_BREAD;
                    mem_rd = 1'b1;
                    if (mem_ack) begin
                        w_next = S_LOOKUP;
                    end
                end
            end
            S_FILL: begin
                snoop_fill = 1'b1;
                w_next     = S_LOOKUP;
            end
            S_WRITE: begin
                func   = C_F_PWRITE;
                w_next = S_RESP;
            end
            S_RESP: begin
                p_ready = 1'b1;
                p_err   = r_err;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_granted   <= 1'b0;
            r_replay    <= '0;
            r_snoop_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && p_req) begin
                r_we     <= p_we;
                r_err    <= 1'b0;
                r_replay <= '0;
            end
            if (r_state == S_LOOKUP && w_lookup_err) begin
                r_err <= 1'b1;
            end
            // Every fill (peer or memory) leads back to a replayed lookup
            if (r_state == S_FILL || (r_state == S_BUS_RD && w_next == S_LOOKUP)) begin
                r_replay <= r_replay + 1'b1;
            end
            r_snoop_cnt <= (r_state == S_SNOOP) ? r_snoop_cnt + 1'b1 : '0;
            r_granted   <= ((r_state == S_WB || r_state == S_BUS_RD) && w_next == r_state)
                           ? w_strobe : 1'b0;
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             w_first_lookup;

    assign w_first_lookup = (r_state == S_LOOKUP) && !w_lookup_err && (r_replay == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_first_lookup && read_hit && r_hit_cnt != '1) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_first_lookup && !read_hit && r_miss_cnt != '1) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// tb_cache_controller : transaction-level model of the MSI controller driving
// directed and randomized requests. Revision: 1.0
// ============================================================================
module tb_cache_controller;

    localparam int SNOOP_WAIT = 4;
    localparam int MAX_REPLAY = 2;
    localparam int CNT_W      = 4;
`ifdef CACHE_CTRL_PERF_EN
    localparam bit C_PERF = 1'b1;
`else
    localparam bit C_PERF = 1'b0;
`endif

    localparam logic [1:0] F_PR = 2'b00, F_PW = 2'b01, F_BR = 2'b10, F_BW = 2'b11;
    // {snoop_out, snoop_fill, bus_req, mem_rd, mem_wr, p_ready, p_err}
    localparam logic [6:0] V_NONE = 7'b0000000, V_SNP = 7'b1000000, V_FILL = 7'b0100000,
                           V_BREQ = 7'b0010000, V_RD  = 7'b0001000, V_WR   = 7'b0000100,
                           V_RDY  = 7'b0000010, V_ERR = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst_n, p_req, p_we, read_hit, snoop_ready, snoop_hit, bus_grant, mem_ack;
    logic [1:0]       stat, func;
    logic             snoop_out, snoop_fill, bus_req, mem_rd, mem_wr, p_ready, p_err;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int exp_hit     = 0;
    int exp_miss    = 0;

    cache_controller #(
        .SNOOP_WAIT (SNOOP_WAIT),
        .MAX_REPLAY (MAX_REPLAY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p_req       (p_req),
        .p_we        (p_we),
        .read_hit    (read_hit),
        .stat        (stat),
        .snoop_ready (snoop_ready),
        .snoop_hit   (snoop_hit),
        .bus_grant   (bus_grant),
        .mem_ack     (mem_ack),
        .func        (func),
        .snoop_out   (snoop_out),
        .snoop_fill  (snoop_fill),
        .bus_req     (bus_req),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .p_ready     (p_ready),
        .p_err       (p_err),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] want(input int n);
        int cap;
        cap = (1 << CNT_W) - 1;
        return C_PERF ? CNT_W'((n > cap) ? cap : n) : '0;
    endfunction

    task automatic noise();
        read_hit    = 1'($urandom_range(0, 1));
        stat        = 2'($urandom_range(0, 3));
        snoop_ready = 1'($urandom_range(0, 1));
        snoop_hit   = 1'($urandom_range(0, 1));
        bus_grant   = 1'($urandom_range(0, 1));
        mem_ack     = 1'($urandom_range(0, 1));
    endtask

    // Inputs are set by the caller just after a rising edge; outputs checked mid-cycle
    task automatic tick(input string tag, input logic [1:0] ef, input logic [6:0] ev);
        logic [6:0] ov;
        @(negedge clk);
        #1;
        ov = {snoop_out, snoop_fill, bus_req, mem_rd, mem_wr, p_ready, p_err};
        vectors++;
        assert (func === ef) else begin
            miscompares++;
            $error("FAIL %s func observed=%b expected=%b", tag, func, ef);
        end
        assert (ov === ev) else begin
            miscompares++;
            $error("FAIL %s outs observed=%b expected=%b", tag, ov, ev);
        end
        assert (hit_cnt === want(exp_hit)) else begin
            miscompares++;
            $error("FAIL %s hit_cnt observed=%0d expected=%0d", tag, hit_cnt, want(exp_hit));
        end
        assert (miss_cnt === want(exp_miss)) else begin
            miscompares++;
            $error("FAIL %s miss_cnt observed=%0d expected=%0d", tag, miss_cnt, want(exp_miss));
        end
        @(posedge clk);
        #1;
    endtask

    // Arbitration wait, granted transfer (grant may wobble), then the ack cycle
    task automatic bus_phase(input string tag, input bit is_wr);
        int         g, a;
        logic [1:0] bf;
        logic [6:0] bv;
        g  = $urandom_range(0, 2);
        a  = $urandom_range(0, 3);
        bf = is_wr ? F_BW : F_BR;
        bv = V_BREQ | (is_wr ? V_WR : V_RD);
        for (int i = 0; i < g; i++) begin
            noise();
            bus_grant = 1'b0;
            tick(tag, F_PR, V_BREQ);
        end
        for (int i = 0; i < a; i++) begin
            noise();
            bus_grant = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            mem_ack   = 1'b0;
            tick(tag, bf, bv);
        end
        noise();
        bus_grant = 1'b1;
        mem_ack   = 1'b1;
        tick(tag, bf, bv);
    endtask

    // peer: 0 silent, 1 supplies line, 2 answers without line, 3 random choice
    task automatic txn(input string tag, input bit we, input logic [1:0] st0,
                       input int hit_at, input int peer);
        int         replay, mode, k;
        bit         done, err, responded;
        logic [1:0] st;
        noise();
        p_req = 1'b1;
        p_we  = we;
        tick(tag, F_PR, V_NONE);
        replay = 0;
        done   = 1'b0;
        err    = 1'b0;
        st     = st0;
        while (!done) begin
            noise();
            p_req    = 1'($urandom_range(0, 1));
            p_we     = 1'($urandom_range(0, 1));
            read_hit = (replay >= hit_at);
            stat     = st;
            tick(tag, F_PR, V_NONE);
            if (replay > MAX_REPLAY) begin
                err  = 1'b1;
                done = 1'b1;
            end else if (replay >= hit_at) begin
                if (replay == 0) exp_hit++;
                if (we) begin
                    noise();
                    tick(tag, F_PW, V_NONE);
                end
                done = 1'b1;
            end else begin
                if (replay == 0) exp_miss++;
                if (st == 2'b11) bus_phase(tag, 1'b1);
                mode      = (peer == 3) ? $urandom_range(0, 2) : peer;
                k         = $urandom_range(0, SNOOP_WAIT - 1);
                responded = 1'b0;
                for (int c = 0; c < SNOOP_WAIT && !responded; c++) begin
                    noise();
                    snoop_ready = (mode != 0 && c == k);
                    if (snoop_ready) snoop_hit = (mode == 1);
                    tick(tag, F_PR, V_SNP);
                    responded = snoop_ready;
                end
                if (responded && mode == 1) begin
                    noise();
                    tick(tag, F_PR, V_FILL);
                end else begin
                    bus_phase(tag, 1'b0);
                end
                replay++;
                st = 2'($urandom_range(0, 3));
            end
        end
        noise();
        p_req = 1'($urandom_range(0, 1));
        tick(tag, F_PR, err ? (V_RDY | V_ERR) : V_RDY);
    endtask

    initial begin
        rst_n = 1'b0;
        p_req = 1'b0;
        p_we  = 1'b0;
        noise();
        repeat (2) @(posedge clk);
        #1;
        tick("reset_state", F_PR, V_NONE);
        rst_n = 1'b1;

        txn("t1_load_hit",   1'b0, 2'b10, 0, 3);
        txn("t2_store_hit",  1'b1, 2'b10, 0, 3);
        txn("t3_dirty_miss", 1'b0, 2'b11, 1, 1);
        txn("t4_peer_quiet", 1'b0, 2'b00, 1, 0);
        txn("t5_replay_err", 1'b0, 2'b01, 99, 1);
        txn("t5_replay_err_st", 1'b1, 2'b00, 99, 3);

        // Reset asserted mid memory read, with grant already withdrawn
        noise();
        p_req = 1'b1;
        p_we  = 1'b0;
        tick("t6_idle", F_PR, V_NONE);
        noise();
        read_hit = 1'b0;
        stat     = 2'b00;
        tick("t6_lookup", F_PR, V_NONE);
        exp_miss++;
        noise();
        snoop_ready = 1'b1;
        snoop_hit   = 1'b0;
        tick("t6_snoop", F_PR, V_SNP);
        noise();
        bus_grant = 1'b1;
        mem_ack   = 1'b0;
        tick("t6_busrd", F_BR, V_BREQ | V_RD);
        bus_grant = 1'b0;
        mem_ack   = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        assert (mem_rd === 1'b1 && func === F_BR) else begin
            miscompares++;
            $error("FAIL t6_grant_lost mem_rd/func observed=%b/%b expected=1/10", mem_rd, func);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        assert ({mem_rd, bus_req, func} === 4'b0000) else begin
            miscompares++;
            $error("FAIL t6_async_rst mem_rd,bus_req,func observed=%b expected=0000",
                   {mem_rd, bus_req, func});
        end
        exp_hit  = 0;
        exp_miss = 0;
        @(posedge clk);
        #1;
        tick("t6_rst_hold", F_PR, V_NONE);
        rst_n = 1'b1;
        p_req = 1'b0;
        tick("t6_idle_after", F_PR, V_NONE);

        for (int n = 0; n < 150; n++) begin
            txn("rand_txn", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 4), 3);
            if ($urandom_range(0, 3) == 0) begin
                noise();
                p_req = 1'b0;
                tick("rand_gap", F_PR, V_NONE);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
